dmem_responder: RTL and testbench

- Data-memory responder that sits on the core's load/store port and services one request at a time.
- The core's memory stage is the initiator: it issues address, write data, memwrite, store_src and load_src over a valid/ready request channel.
- The block performs byte, halfword or word stores and sign- or zero-extended loads on a word-organised little-endian array.
- It returns each result on a valid/ready response channel after a programmable latency, so the pipeline hazard unit sees realistic stalls.

---
 rtl/mem_pkg.sv | 42 ++++
 rtl/dmem_responder_if.sv | 35 +++
 rtl/lsu_align.sv | 77 +++++++
 rtl/dmem_responder.sv | 168 ++++++++++++++++
 tb/tb_dmem_responder.sv | 248 ++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module      : mem_pkg
// Description : Shared encodings for the data-memory responder: store/load
//               size selectors, FSM state encoding, latency counter width.
// Revision    : 1.0 - initial release
// ============================================================================
package mem_pkg;

    // Width of the latency counter; covers LATENCY values 1..15.
    localparam int C_LAT_W = 4;

    // Store size selector.
    localparam logic [1:0] C_ST_SW = 2'b00;
    localparam logic [1:0] C_ST_SH = 2'b01;
    localparam logic [1:0] C_ST_SB = 2'b10;

    // Load size/extension selector.
    localparam logic [2:0] C_LD_LW  = 3'b000;
    localparam logic [2:0] C_LD_LH  = 3'b001;
    localparam logic [2:0] C_LD_LB  = 3'b010;
    localparam logic [2:0] C_LD_LHU = 3'b011;
    localparam logic [2:0] C_LD_LBU = 3'b100;

    // Responder FSM encoding.
    typedef logic [1:0] state_t;
    localparam state_t C_S_IDLE = 2'd0;
    localparam state_t C_S_WAIT = 2'd1;
    localparam state_t C_S_RESP = 2'd2;

    // Only the selector relevant to the access direction is validated.
    function automatic logic src_illegal(input logic       we,
                                         input logic [1:0] store_src,
                                         input logic [2:0] load_src);
        if (we)
            return (store_src == 2'b11);
        else
            return (load_src > C_LD_LBU);
    endfunction

endpackage
`default_nettype wire

// File: rtl/dmem_responder_if.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder_if
// Description : Request/response channels between the memory stage
//               (master) and the data-memory responder (slave).
// Revision    : 1.0 - initial release
// ============================================================================
interface dmem_responder_if #(
    parameter int ADDR_W = 32
);
    logic              req_valid;
    logic              req_ready;
    logic              req_we;
    logic [ADDR_W-1:0] req_addr;
    logic [31:0]       req_wdata;
    logic [1:0]        req_store_src;
    logic [2:0]        req_load_src;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [31:0]       rsp_rdata;
    logic              rsp_err;

    modport master (
        output req_valid, req_we, req_addr, req_wdata, req_store_src,
               req_load_src, rsp_ready,
        input  req_ready, rsp_valid, rsp_rdata, rsp_err
    );

    modport slave (
        input  req_valid, req_we, req_addr, req_wdata, req_store_src,
               req_load_src, rsp_ready,
        output req_ready, rsp_valid, rsp_rdata, rsp_err
    );
endinterface
`default_nettype wire

// File: rtl/lsu_align.sv
`default_nettype none
// ============================================================================
// Module      : lsu_align
// Description : Byte-lane steering for a little-endian 32-bit word: merges
//               store data into the old word, extracts/extends load data and
//               flags natural-alignment violations.
// Revision    : 1.0 - initial release
// ============================================================================
module lsu_align
    import mem_pkg::*;
(
    input  logic [31:0] word,
    input  logic [1:0]  lane,
    input  logic [31:0] wdata,
    input  logic        we,
    input  logic [1:0]  store_src,
    input  logic [2:0]  load_src,
    output logic [31:0] store_word,
    output logic [31:0] load_data,
    output logic        misalign
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    assign w_byte = word[{lane, 3'b000} +: 8];
    assign w_half = lane[1] ? word[31:16] : word[15:0];

    // Replace only the addressed bytes; everything else keeps the old value.
    always_comb begin
        store_word = word;
        case (store_src)
            C_ST_SW: store_word = wdata;
            C_ST_SH: begin
                if (lane[1])
                    store_word[31:16] = wdata[15:0];
                else
                    store_word[15:0]  = wdata[15:0];
            end
            C_ST_SB: store_word[{lane, 3'b000} +: 8] = wdata[7:0];
            default: store_word = word;
        endcase
    end

    // Right-align the selected byte/half and sign- or zero-extend it.
    always_comb begin
        load_data = 32'd0;
        case (load_src)
            C_LD_LW:  load_data = word;
            C_LD_LH:  load_data = {{16{w_half[15]}}, w_half};
            C_LD_LB:  load_data = {{24{w_byte[7]}}, w_byte};
            C_LD_LHU: load_data = {16'd0, w_half};
            C_LD_LBU: load_data = {24'd0, w_byte};
            default:  load_data = 32'd0;
        endcase
    end

    // Words need lane 0, halves need an even lane, bytes are always aligned.
    always_comb begin
        misalign = 1'b0;
        if (we) begin
            case (store_src)
                C_ST_SW: misalign = (lane != 2'b00);
                C_ST_SH: misalign = lane[0];
                default: misalign = 1'b0;
            endcase
        end else begin
            case (load_src)
                C_LD_LW:           misalign = (lane != 2'b00);
                C_LD_LH, C_LD_LHU: misalign = lane[0];
                default:           misalign = 1'b0;
            endcase
        end
    end

endmodule
`default_nettype wire

// File: rtl/dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : dmem_responder
// Description : Single-outstanding data-memory responder. Accepts one
//               load/store, commits it LATENCY cycles later and holds the
//               response until the initiator takes it.
// Revision    : 1.0 - initial release
// ============================================================================
module dmem_responder
    import mem_pkg::*;
#(
    parameter int DEPTH_WORDS = 1024,
    parameter int LATENCY     = 2,
    parameter int ADDR_W      = 32
) (
    input  logic             clk,
    input  logic             rst,
    dmem_responder_if.slave  bus
);

    localparam int                 C_IDX_W    = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;
    localparam logic [ADDR_W-3:0]  C_DEPTH    = (ADDR_W-2)'(DEPTH_WORDS);
    localparam logic [C_LAT_W-1:0] C_CNT_INIT = C_LAT_W'(LATENCY - 1);

    state_t              r_state;
    state_t              w_next;
    logic [C_LAT_W-1:0]  r_cnt;

    logic                r_we;
    logic [ADDR_W-1:0]   r_addr;
    logic [31:0]         r_wdata;
    logic [1:0]          r_store_src;
    logic [2:0]          r_load_src;

    logic                r_rsp_valid;
    logic [31:0]         r_rsp_rdata;
    logic                r_rsp_err;

    logic [31:0]         mem [DEPTH_WORDS];

    logic                w_req_ready;
    logic                w_accept;
    logic                w_enter_resp;
    logic                w_op_we;
    logic [ADDR_W-1:0]   w_op_addr;
    logic [31:0]         w_op_wdata;
    logic [1:0]          w_op_store_src;
    logic [2:0]          w_op_load_src;
    logic [C_IDX_W-1:0]  w_idx;
    logic [31:0]         w_word;
    logic [31:0]         w_store_word;
    logic [31:0]         w_load_data;
    logic                w_misalign;
    logic                w_range_err;
    logic                w_err;

    assign w_accept = bus.req_valid && w_req_ready;

    // Commit happens on the edge entering RESP; reset always wins.
    assign w_enter_resp = !rst && (r_state != C_S_RESP) && (w_next == C_S_RESP);

    // With LATENCY == 1 the commit edge is the accept edge, so the live
    // request is used; otherwise the latched copy is.
    assign w_op_we        = (r_state == C_S_IDLE) ? bus.req_we        : r_we;
    assign w_op_addr      = (r_state == C_S_IDLE) ? bus.req_addr      : r_addr;
    assign w_op_wdata     = (r_state == C_S_IDLE) ? bus.req_wdata     : r_wdata;
    assign w_op_store_src = (r_state == C_S_IDLE) ? bus.req_store_src : r_store_src;
    assign w_op_load_src  = (r_state == C_S_IDLE) ? bus.req_load_src  : r_load_src;

    assign w_idx       = w_op_addr[C_IDX_W+1:2];
    assign w_word      = mem[w_idx];
    assign w_range_err = (w_op_addr[ADDR_W-1:2] >= C_DEPTH);
    assign w_err       = w_range_err || w_misalign
                       || src_illegal(w_op_we, w_op_store_src, w_op_load_src);

    lsu_align u_align (
        .word       (w_word),
        .lane       (w_op_addr[1:0]),
        .wdata      (w_op_wdata),
        .we         (w_op_we),
        .store_src  (w_op_store_src),
        .load_src   (w_op_load_src),
        .store_word (w_store_word),
        .load_data  (w_load_data),
        .misalign   (w_misalign)
    );

    // State register.
    always_ff @(posedge clk) begin
        if (rst)
            r_state <= C_S_IDLE;
        else
            r_state <= w_next;
    end

    // Next-state: IDLE -> WAIT/RESP on accept, WAIT -> RESP as the counter
    // expires, RESP -> IDLE on the response handshake.
    always_comb begin
        w_next = r_state;
        case (r_state)
            C_S_IDLE: begin
                if (w_accept)
                    w_next = (LATENCY > 1) ? C_S_WAIT : C_S_RESP;
            end
            C_S_WAIT: begin
                if (r_cnt == C_LAT_W'(1))
                    w_next = C_S_RESP;
            end
            C_S_RESP: begin
                if (r_rsp_valid && bus.rsp_ready)
                    w_next = C_S_IDLE;
            end
            default: w_next = C_S_IDLE;
        endcase
    end

    // Outputs: ready only in IDLE and never while reset is asserted.
    always_comb begin
        w_req_ready = !rst && (r_state == C_S_IDLE);
    end

    assign bus.req_ready = w_req_ready;
    assign bus.rsp_valid = r_rsp_valid;
    assign bus.rsp_rdata = r_rsp_rdata;
    assign bus.rsp_err   = r_rsp_err;

    // Request latch, latency counter and the held response.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt       <= '0;
            r_we        <= 1'b0;
            r_addr      <= '0;
            r_wdata     <= 32'd0;
            r_store_src <= 2'b00;
            r_load_src  <= 3'b000;
            r_rsp_valid <= 1'b0;
            r_rsp_rdata <= 32'd0;
            r_rsp_err   <= 1'b0;
        end else begin
            if (w_accept) begin
                r_we        <= bus.req_we;
                r_addr      <= bus.req_addr;
                r_wdata     <= bus.req_wdata;
                r_store_src <= bus.req_store_src;
                r_load_src  <= bus.req_load_src;
                r_cnt       <= C_CNT_INIT;
            end else if (r_state == C_S_WAIT) begin
                r_cnt <= r_cnt - C_LAT_W'(1);
            end

            if (w_enter_resp) begin
                r_rsp_valid <= 1'b1;
                r_rsp_err   <= w_err;
                r_rsp_rdata <= (w_err || w_op_we) ? 32'd0 : w_load_data;
            end else if (r_state == C_S_RESP && r_rsp_valid && bus.rsp_ready) begin
                r_rsp_valid <= 1'b0;
            end
        end
    end

    // Array write at the commit edge; contents survive reset.
    always_ff @(posedge clk) begin
        if (w_enter_resp && w_op_we && !w_err)
            mem[w_idx] <= w_store_word;
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_responder.sv
`default_nettype none
// ============================================================================
// Module      : tb_dmem_responder
// Description : Directed self-checking bench for dmem_responder at
//               LATENCY 2, 4 and 1.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_dmem_responder;
    import mem_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    int          sel;
    logic        req_valid, req_we, rsp_ready;
    logic [31:0] req_addr, req_wdata;
    logic [1:0]  req_store_src;
    logic [2:0]  req_load_src;
    logic        req_ready, rsp_valid, rsp_err;
    logic [31:0] rsp_rdata;

    int          n_vec = 0;
    int          n_err = 0;
    int          last_lat;

    always #5 clk = ~clk;

    dmem_responder_if #(.ADDR_W(32)) if_l2 ();
    dmem_responder_if #(.ADDR_W(32)) if_l4 ();
    dmem_responder_if #(.ADDR_W(32)) if_l1 ();

    assign if_l2.req_valid = req_valid && (sel == 0);
    assign if_l4.req_valid = req_valid && (sel == 1);
    assign if_l1.req_valid = req_valid && (sel == 2);
    assign if_l2.req_we = req_we;            assign if_l4.req_we = req_we;            assign if_l1.req_we = req_we;
    assign if_l2.req_addr = req_addr;        assign if_l4.req_addr = req_addr;        assign if_l1.req_addr = req_addr;
    assign if_l2.req_wdata = req_wdata;      assign if_l4.req_wdata = req_wdata;      assign if_l1.req_wdata = req_wdata;
    assign if_l2.req_store_src = req_store_src; assign if_l4.req_store_src = req_store_src; assign if_l1.req_store_src = req_store_src;
    assign if_l2.req_load_src = req_load_src;   assign if_l4.req_load_src = req_load_src;   assign if_l1.req_load_src = req_load_src;
    assign if_l2.rsp_ready = rsp_ready;      assign if_l4.rsp_ready = rsp_ready;      assign if_l1.rsp_ready = rsp_ready;

    always_comb begin
        case (sel)
            1:       {req_ready, rsp_valid, rsp_err, rsp_rdata} = {if_l4.req_ready, if_l4.rsp_valid, if_l4.rsp_err, if_l4.rsp_rdata};
            2:       {req_ready, rsp_valid, rsp_err, rsp_rdata} = {if_l1.req_ready, if_l1.rsp_valid, if_l1.rsp_err, if_l1.rsp_rdata};
            default: {req_ready, rsp_valid, rsp_err, rsp_rdata} = {if_l2.req_ready, if_l2.rsp_valid, if_l2.rsp_err, if_l2.rsp_rdata};
        endcase
    end

    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(2), .ADDR_W(32)) u_dut_l2 (.clk(clk), .rst(rst), .bus(if_l2));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(4), .ADDR_W(32)) u_dut_l4 (.clk(clk), .rst(rst), .bus(if_l4));
    dmem_responder #(.DEPTH_WORDS(1024), .LATENCY(1), .ADDR_W(32)) u_dut_l1 (.clk(clk), .rst(rst), .bus(if_l1));

    task automatic check_vec(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One complete transaction with rsp_ready high; scrambles req_* after accept.
    task automatic do_req(input logic we, input logic [31:0] addr, input logic [31:0] wdata,
                          input logic [1:0] ss, input logic [2:0] ls,
                          output logic [31:0] rdata, output logic err);
        int n;
        req_we = we; req_addr = addr; req_wdata = wdata;
        req_store_src = ss; req_load_src = ls; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        if (n >= 50) check_vec("accept_timeout", 32'd1, 32'd0);
        tick();
        req_valid = 1'b0;
        req_we = 1'($urandom); req_addr = $urandom; req_wdata = $urandom;
        req_store_src = 2'($urandom); req_load_src = 3'($urandom);
        last_lat = 1;
        while (!rsp_valid && last_lat < 50) begin tick(); last_lat++; end
        if (!rsp_valid) check_vec("rsp_timeout", 32'd0, 32'd1);
        rdata = rsp_rdata;
        err   = rsp_err;
        tick();
    endtask

    task automatic store(input string tag, input logic [31:0] addr, input logic [31:0] data,
                         input logic [1:0] ss, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        do_req(1'b1, addr, data, ss, C_LD_LW, rd, er);
        check_vec({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_vec({tag, "_rdata"}, rd, 32'd0);
    endtask

    task automatic load(input string tag, input logic [31:0] addr, input logic [2:0] ls,
                        input logic [31:0] exp_data, input logic exp_err);
        logic [31:0] rd;
        logic        er;
        do_req(1'b0, addr, 32'd0, C_ST_SW, ls, rd, er);
        check_vec({tag, "_err"}, {31'd0, er}, {31'd0, exp_err});
        check_vec({tag, "_rdata"}, rd, exp_data);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int          n;
        logic        seen;
        int          n_acc, n_rsp;
        int          acc_cyc [4];
        logic        acc_now;
        logic [31:0] b2b_data [4];

        b2b_data = '{32'hC0DE0001, 32'h8000FFFE, 32'h0BADF00D, 32'h76543210};
        rst = 1'b1; sel = 0; req_valid = 1'b0; req_we = 1'b0; req_addr = 32'd0;
        req_wdata = 32'd0; req_store_src = C_ST_SW; req_load_src = C_LD_LW; rsp_ready = 1'b1;

        // Reset state
        repeat (3) tick();
        check_vec("rst_req_ready", {31'd0, req_ready}, 32'd0);
        check_vec("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        check_vec("rst_rsp_rdata", rsp_rdata, 32'd0);
        check_vec("rst_rsp_err", {31'd0, rsp_err}, 32'd0);
        rst = 1'b0;
        #1;
        check_vec("idle_req_ready", {31'd0, req_ready}, 32'd1);

        // LATENCY = 2: word, byte and half accesses
        store("sw_10", 32'h10, 32'hDEADBEEF, C_ST_SW, 1'b0);
        check_vec("sw_latency", 32'(last_lat), 32'd2);
        load("lw_10", 32'h10, C_LD_LW, 32'hDEADBEEF, 1'b0);
        store("sb_13", 32'h13, 32'h1234565A, C_ST_SB, 1'b0);
        load("lw_after_sb", 32'h10, C_LD_LW, 32'h5AADBEEF, 1'b0);
        load("lb_13", 32'h13, C_LD_LB, 32'h0000005A, 1'b0);
        load("lh_12", 32'h12, C_LD_LH, 32'h00005AAD, 1'b0);
        load("lbu_11", 32'h11, C_LD_LBU, 32'h000000BE, 1'b0);
        load("lb_11", 32'h11, C_LD_LB, 32'hFFFFFFBE, 1'b0);
        load("lhu_10", 32'h10, C_LD_LHU, 32'h0000BEEF, 1'b0);
        load("lh_10", 32'h10, C_LD_LH, 32'hFFFFBEEF, 1'b0);
        store("sh_14", 32'h14, 32'hCAFE8001, C_ST_SH, 1'b0);
        load("lh_14", 32'h14, C_LD_LH, 32'hFFFF8001, 1'b0);
        load("lhu_14", 32'h14, C_LD_LHU, 32'h00008001, 1'b0);
        store("sh_16", 32'h16, 32'h00007FFF, C_ST_SH, 1'b0);
        load("lw_14", 32'h14, C_LD_LW, 32'h7FFF8001, 1'b0);

        // Error cases: err set, rdata zero, no array update
        store("sh_mis", 32'h11, 32'h0000FFFF, C_ST_SH, 1'b1);
        store("sw_mis", 32'h12, 32'h00000000, C_ST_SW, 1'b1);
        load("lw_mis", 32'h12, C_LD_LW, 32'd0, 1'b1);
        load("lh_mis", 32'h13, C_LD_LH, 32'd0, 1'b1);
        load("lw_oor", 32'd1024 * 4, C_LD_LW, 32'd0, 1'b1);
        store("st_illegal", 32'h10, 32'h00000000, 2'b11, 1'b1);
        load("ld_illegal", 32'h10, 3'b101, 32'd0, 1'b1);
        load("lw_unchanged", 32'h10, C_LD_LW, 32'h5AADBEEF, 1'b0);

        // Backpressure: response held while rsp_ready is low
        rsp_ready = 1'b0;
        req_we = 1'b0; req_addr = 32'h10; req_load_src = C_LD_LW; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        n = 0;
        while (!rsp_valid && n < 50) begin tick(); n++; end
        check_vec("bp_rsp_seen", {31'd0, rsp_valid}, 32'd1);
        repeat (5) begin
            tick();
            check_vec("bp_valid_held", {31'd0, rsp_valid}, 32'd1);
            check_vec("bp_rdata_held", rsp_rdata, 32'h5AADBEEF);
            check_vec("bp_req_ready_low", {31'd0, req_ready}, 32'd0);
        end
        rsp_ready = 1'b1;
        tick();
        check_vec("bp_valid_cleared", {31'd0, rsp_valid}, 32'd0);
        check_vec("bp_back_idle", {31'd0, req_ready}, 32'd1);
        tick();
        check_vec("bp_no_dup", {31'd0, rsp_valid}, 32'd0);

        // LATENCY = 4: reset during WAIT discards the store
        sel = 1;
        tick();
        store("l4_sw_init", 32'h20, 32'h11111111, C_ST_SW, 1'b0);
        check_vec("l4_latency", 32'(last_lat), 32'd4);
        req_we = 1'b1; req_addr = 32'h20; req_wdata = 32'h12345678;
        req_store_src = C_ST_SW; req_valid = 1'b1;
        n = 0;
        while (!req_ready && n < 50) begin tick(); n++; end
        tick();
        req_valid = 1'b0;
        tick();
        rst = 1'b1;
        req_wdata = 32'h99999999; req_valid = 1'b1;
        #1;
        check_vec("rst_mid_req_ready", {31'd0, req_ready}, 32'd0);
        repeat (3) begin
            tick();
            check_vec("rst_mid_rsp_valid", {31'd0, rsp_valid}, 32'd0);
            check_vec("rst_mid_req_ready_hold", {31'd0, req_ready}, 32'd0);
        end
        rst = 1'b0;
        req_valid = 1'b0;
        seen = 1'b0;
        repeat (8) begin
            tick();
            if (rsp_valid) seen = 1'b1;
        end
        check_vec("rst_no_rsp", {31'd0, seen}, 32'd0);
        load("l4_lw_20", 32'h20, C_LD_LW, 32'h11111111, 1'b0);

        // LATENCY = 1: back-to-back loads with rsp_ready tied high
        sel = 2;
        tick();
        for (int i = 0; i < 4; i++)
            store("l1_sw", 32'h100 + 32'(4 * i), b2b_data[i], C_ST_SW, 1'b0);
        check_vec("l1_latency", 32'(last_lat), 32'd1);
        n_acc = 0; n_rsp = 0;
        req_we = 1'b0; req_load_src = C_LD_LW; req_addr = 32'h100; req_valid = 1'b1;
        for (int cyc = 0; cyc < 20; cyc++) begin
            if (rsp_valid) begin
                if (n_rsp < 4) check_vec("l1_rdata", rsp_rdata, b2b_data[n_rsp]);
                n_rsp++;
            end
            acc_now = req_valid && req_ready;
            tick();
            if (acc_now && n_acc < 4) begin
                acc_cyc[n_acc] = cyc;
                n_acc++;
                if (n_acc == 4) req_valid = 1'b0;
                else req_addr = 32'h100 + 32'(4 * n_acc);
            end
        end
        check_vec("l1_n_accepted", 32'(n_acc), 32'd4);
        check_vec("l1_n_responses", 32'(n_rsp), 32'd4);
        for (int i = 1; i < 4; i++)
            check_vec("l1_accept_gap", 32'(acc_cyc[i] - acc_cyc[i-1]), 32'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
`default_nettype wire
